ex_unit: RTL and testbench

// - Execute stage: consumer of the decode bundle (aluop/alusel/reg1/reg2/wd/wreg).
// - Registers the bundle, computes the result, and presents {wd, wreg, wdata} to the MEM stage.
// - Logic, shift and add ops complete in 1 cycle; DIVU is iterative (32 cycles) and back-pressures decode.

---
 rtl/ex_unit_if.sv | 27 ++
 rtl/ex_unit.sv | 212 +++++++++++++++++++++
 tb/tb_ex_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_unit_if.sv
// Decode-to-execute bundle and execute-to-MEM result, grouped as one port.
// master drives decode side (and flush); slave is the execute stage.
interface ex_unit_if;
    logic        flush_i;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        ex_valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    modport master (
        output flush_i, id_valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  id_ready_o, ex_valid_o, wd_o, wreg_o, wdata_o
    );

    modport slave (
        input  flush_i, id_valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output id_ready_o, ex_valid_o, wd_o, wreg_o, wdata_o
    );
endinterface

// File: rtl/ex_unit.sv
// Execute stage: single-cycle logic/shift/add, optional iterative unsigned divider.
// Define EX_DIV_EN to build the divider (IDLE/DIV/DONE FSM); otherwise DIVU yields 0.
module ex_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_unit_if.slave bus
);

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Single-cycle result; DIVU only contributes its divide-by-zero value here.
    function automatic logic [31:0] f_result(input logic [7:0]  op,
                                             input logic [2:0]  sel,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sb;
        logic        [31:0] res;
        sb  = signed'(b);
        res = '0;
        case (sel)
            SEL_LOGIC: begin
                case (op)
                    OP_OR:   res = a | b;
                    OP_AND:  res = a & b;
                    OP_XOR:  res = a ^ b;
                    OP_NOR:  res = ~(a | b);
                    default: res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (op)
                    OP_SLL:  res = b << a[4:0];
                    OP_SRL:  res = b >> a[4:0];
                    OP_SRA:  res = unsigned'(sb >>> a[4:0]);
                    default: res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (op)
                    OP_ADDU: res = a + b;
                    OP_DIVU: res = (DIV_EN && (b == '0)) ? '1 : '0;
                    default: res = '0;
                endcase
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    logic        w_ready;
    logic        w_accept;
    logic        w_start_div;
    logic        w_div_last;
    logic [31:0] w_div_q;
    logic [4:0]  w_div_wd;
    logic        w_div_wreg;
    logic [31:0] w_alu;

    logic        r_ex_valid;
    logic [4:0]  r_wd_o;
    logic        r_wreg_o;
    logic [31:0] r_wdata_o;

    assign w_accept = bus.id_valid_i & w_ready & ~bus.flush_i;
    assign w_alu    = f_result(bus.aluop_i, bus.alusel_i, bus.reg1_i, bus.reg2_i);

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [5:0]  r_cnt;
    logic [4:0]  r_div_wd;
    logic        r_div_wreg;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    assign w_ready     = (r_state != S_DIV);
    assign w_start_div = w_accept && (bus.aluop_i == OP_DIVU) &&
                         (bus.alusel_i == SEL_ARITH) && (bus.reg2_i != '0);

    // Restoring step: bit 32 of the trial difference is the borrow.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[31]};
        w_diff    = w_rem_sh - {1'b0, r_dvsr};
        w_quo_nxt = {r_quo[30:0], ~w_diff[32]};
        w_rem_nxt = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_last  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = w_start_div ? S_DIV : S_IDLE;
            S_DIV: begin
                if (r_cnt == CNT_LAST) begin
                    w_div_last  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_nxt = S_IDLE;
            w_div_last  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_cnt      <= '0;
            r_div_wd   <= '0;
            r_div_wreg <= 1'b0;
        end else if (w_start_div) begin
            r_rem      <= '0;
            r_quo      <= bus.reg1_i;
            r_dvsr     <= bus.reg2_i;
            r_cnt      <= '0;
            r_div_wd   <= bus.wd_i;
            r_div_wreg <= bus.wreg_i;
        end else if ((r_state == S_DIV) && !bus.flush_i) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign w_div_q    = w_quo_nxt;
    assign w_div_wd   = r_div_wd;
    assign w_div_wreg = r_div_wreg;
`else
    logic w_unused_cfg;

    assign w_ready      = 1'b1;
    assign w_start_div  = 1'b0;
    assign w_div_last   = 1'b0;
    assign w_div_q      = '0;
    assign w_div_wd     = '0;
    assign w_div_wreg   = 1'b0;
    assign w_unused_cfg = (DIV_CYCLES != 0);
`endif

    // Result register: valid pulses for one cycle, payload holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid <= 1'b0;
            r_wd_o     <= '0;
            r_wreg_o   <= 1'b0;
            r_wdata_o  <= '0;
        end else begin
            r_ex_valid <= 1'b0;
            if (bus.flush_i) begin
                r_wreg_o <= 1'b0;
            end else if (w_accept && !w_start_div) begin
                r_ex_valid <= 1'b1;
                r_wd_o     <= bus.wd_i;
                r_wreg_o   <= bus.wreg_i;
                r_wdata_o  <= w_alu;
            end else if (w_div_last) begin
                r_ex_valid <= 1'b1;
                r_wd_o     <= w_div_wd;
                r_wreg_o   <= w_div_wreg;
                r_wdata_o  <= w_div_q;
            end
        end
    end

    assign bus.id_ready_o = w_ready;
    assign bus.ex_valid_o = r_ex_valid;
    assign bus.wd_o       = r_wd_o;
    assign bus.wreg_o     = r_wreg_o;
    assign bus.wdata_o    = r_wdata_o;

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit; covers both the default build and EX_DIV_EN.
module tb_ex_unit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    ex_unit_if bus ();

    ex_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        bus.id_valid_i = v;
        bus.aluop_i    = op;
        bus.alusel_i   = sel;
        bus.reg1_i     = a;
        bus.reg2_i     = b;
        bus.wd_i       = wd;
        bus.wreg_i     = wr;
    endtask

    logic [7:0]  t_op  [8] = '{8'h26, 8'h24, 8'h27, 8'h02, 8'h21, 8'h99, 8'h25, 8'h7C};
    logic [2:0]  t_sel [8] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b001};
    logic [31:0] t_a   [8] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h0000_FFFF, 32'h0000_0024,
                               32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0001, 32'h0000_0004};
    logic [31:0] t_b   [8] = '{32'hFF00_FF00, 32'hFF00_FF00, 32'h00FF_0000, 32'hF000_0000,
                               32'h0000_0002, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001};
    logic [31:0] t_exp [8] = '{32'h0FF0_0FF0, 32'hF000_F000, 32'hFF00_0000, 32'h0F00_0000,
                               32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.flush_i = 1'($urandom());
            drive(1'($urandom()), 8'($urandom()), 3'($urandom()), $urandom(), $urandom(),
                  5'($urandom()), 1'($urandom()));
            tick();
            chk("rst_ex_valid", 32'(bus.ex_valid_o), 32'd0);
            chk("rst_id_ready", 32'(bus.id_ready_o), 32'd1);
        end
        chk("rst_wd", 32'(bus.wd_o), 32'd0);
        chk("rst_wreg", 32'(bus.wreg_o), 32'd0);
        chk("rst_wdata", bus.wdata_o, 32'd0);

        bus.flush_i = 1'b0;
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();

        // ORI path
        drive(1'b1, 8'h25, 3'b001, 32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("ori_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("ori_wdata", bus.wdata_o, 32'h0000_1120);
        chk("ori_wd", 32'(bus.wd_o), 32'd5);
        chk("ori_wreg", 32'(bus.wreg_o), 32'd1);
        tick();
        chk("ori_pulse_end", 32'(bus.ex_valid_o), 32'd0);
        chk("ori_hold", bus.wdata_o, 32'h0000_1120);

        // SRA then SLL back-to-back
        drive(1'b1, 8'h03, 3'b010, 32'd4, 32'h8000_0000, 5'd7, 1'b1);
        tick();
        chk("sra_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("sra_wdata", bus.wdata_o, 32'hF800_0000);
        drive(1'b1, 8'h7C, 3'b010, 32'd31, 32'd1, 5'd8, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("sll_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("sll_wdata", bus.wdata_o, 32'h8000_0000);
        chk("sll_wd", 32'(bus.wd_o), 32'd8);

        // Op table, one per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, t_op[i], t_sel[i], t_a[i], t_b[i], 5'(i + 10), 1'b1);
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.ex_valid_o), 32'd1);
            chk($sformatf("tbl%0d_wdata", i), bus.wdata_o, t_exp[i]);
            chk($sformatf("tbl%0d_wd", i), 32'(bus.wd_o), 32'(i + 10));
        end
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        tick();

        // Divide by zero
        drive(1'b1, 8'h1B, 3'b100, 32'd5, 32'd0, 5'd3, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("dz_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("dz_ready", 32'(bus.id_ready_o), 32'd1);
`ifdef EX_DIV_EN
        chk("dz_wdata", bus.wdata_o, 32'hFFFF_FFFF);
`else
        chk("dz_wdata", bus.wdata_o, 32'h0000_0000);
`endif
        tick();

        // DIVU 100 / 7
        drive(1'b1, 8'h1B, 3'b100, 32'd100, 32'd7, 5'd6, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
`ifdef EX_DIV_EN
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("div_c%0d_ready", i), 32'(bus.id_ready_o), 32'd0);
            chk($sformatf("div_c%0d_valid", i), 32'(bus.ex_valid_o), 32'd0);
            tick();
        end
        chk("div_done_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("div_done_wdata", bus.wdata_o, 32'd14);
        chk("div_done_wd", 32'(bus.wd_o), 32'd6);
        chk("div_done_ready", 32'(bus.id_ready_o), 32'd1);
        drive(1'b1, 8'h25, 3'b001, 32'h0000_0F00, 32'h0000_000F, 5'd9, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("overlap_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("overlap_wdata", bus.wdata_o, 32'h0000_0F0F);
        chk("overlap_wd", 32'(bus.wd_o), 32'd9);
        tick();

        // Flush at divide cycle 10, with a bundle offered during the flush
        drive(1'b1, 8'h1B, 3'b100, 32'd1000, 32'd3, 5'd2, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        bus.flush_i = 1'b1;
        drive(1'b1, 8'h25, 3'b001, 32'h1, 32'h2, 5'd1, 1'b1);
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("dflush_ready", 32'(bus.id_ready_o), 32'd1);
        chk("dflush_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("dflush_wreg", 32'(bus.wreg_o), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk($sformatf("dflush_quiet%0d", i), 32'(bus.ex_valid_o), 32'd0);
        end
`else
        chk("div_off_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("div_off_wdata", bus.wdata_o, 32'd0);
        chk("div_off_ready", 32'(bus.id_ready_o), 32'd1);
        tick();
        chk("div_off_ready2", 32'(bus.id_ready_o), 32'd1);
`endif

        // Flush beats a valid single-cycle bundle
        drive(1'b1, 8'h25, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd11, 1'b1);
        tick();
        chk("pre_flush_valid", 32'(bus.ex_valid_o), 32'd1);
        bus.flush_i = 1'b1;
        drive(1'b1, 8'h21, 3'b100, 32'd1, 32'd1, 5'd12, 1'b1);
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("flush_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("flush_wreg", 32'(bus.wreg_o), 32'd0);
        chk("flush_wdata_hold", bus.wdata_o, 32'h0000_00FF);
        chk("flush_ready", 32'(bus.id_ready_o), 32'd1);

        // Async reset mid-operation
        drive(1'b1, 8'h25, 3'b001, 32'hA000_0000, 32'h0000_000A, 5'd13, 1'b1);
        tick();
`ifdef EX_DIV_EN
        drive(1'b1, 8'h1B, 3'b100, 32'd50, 32'd5, 5'd14, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_arst_ready", 32'(bus.id_ready_o), 32'd0);
`else
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
`endif
        chk("pre_arst_wdata", bus.wdata_o, 32'hA000_000A);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("arst_wdata", bus.wdata_o, 32'd0);
        chk("arst_wd", 32'(bus.wd_o), 32'd0);
        chk("arst_wreg", 32'(bus.wreg_o), 32'd0);
        chk("arst_ready", 32'(bus.id_ready_o), 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("post_arst_quiet%0d", i), 32'(bus.ex_valid_o), 32'd0);
        end

        // Recovery after reset
        drive(1'b1, 8'h21, 3'b100, 32'd40, 32'd2, 5'd15, 1'b0);
        tick();
        drive(1'b0, 8'h00, 3'b000, '0, '0, '0, 1'b0);
        chk("recover_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("recover_wdata", bus.wdata_o, 32'd42);
        chk("recover_wreg", 32'(bus.wreg_o), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
